// File: rtl/cpu_run_pkg.sv
`default_nettype none
// ============================================================================
// cpu_run_pkg : state encoding and halt-instruction decode for cpu_run_ctrl
// Rev 1.0
// ============================================================================
package cpu_run_pkg;

    localparam logic [4:0] DEFAULT_HALT_OPCODE = 5'b11100;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        RD    = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } run_state_e;

    // Halt = opcode match with the operand field all-zero or all-one.
    function automatic logic is_halt(
        input logic [63:0] instr,
        input int          instr_w,
        input int          opcode_w,
        input logic [63:0] halt_opcode
    );
        logic [63:0] opmask;
        logic [63:0] operand;
        logic [63:0] opcode;
        int          op_w;
        op_w    = instr_w - opcode_w;
        opmask  = (64'd1 << op_w) - 64'd1;
        operand = instr & opmask;
        opcode  = (instr >> op_w) & ((64'd1 << opcode_w) - 64'd1);
        return (opcode == halt_opcode) && ((operand == 64'd0) || (operand == opmask));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_cnt.sv
`default_nettype none
// ============================================================================
// cpu_run_cnt : loadable down-counter with zero / one terminal flags
// Rev 1.0
// ============================================================================
module cpu_run_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_one
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
    assign o_one  = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// cpu_run_ctrl : core reset sequencing, halt detection, pipeline drain and
//                data-memory window dump over a valid/ready stream
// Rev 1.0
// ============================================================================
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int                  INSTR_W      = 16,
    parameter int                  OPCODE_W     = 5,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE  = DEFAULT_HALT_OPCODE,
    parameter int                  ADDR_W       = 8,
    parameter int                  DATA_W       = 16,
    parameter int                  HOLD_CYCLES  = 4,
    parameter int                  DRAIN_CYCLES = 10,
    parameter int                  DUMP_BASE    = 1,
    parameter int                  DUMP_COUNT   = 1,
    parameter int                  RUN_TIMEOUT  = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic [INSTR_W-1:0] instr,
    output logic               core_reset,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [DATA_W-1:0]  dump_data,
    output logic               dump_last,
    output logic               done,
    output logic               timed_out
);

    localparam int c_CNT_MAX0 = (HOLD_CYCLES > DRAIN_CYCLES) ? HOLD_CYCLES : DRAIN_CYCLES;
    localparam int c_CNT_MAX  = (c_CNT_MAX0 > DUMP_COUNT) ? c_CNT_MAX0 : DUMP_COUNT;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam int c_RUN_W    = (RUN_TIMEOUT < 2) ? 1 : $clog2(RUN_TIMEOUT + 1);

    run_state_e          r_state;
    logic                r_core_reset;
    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_dump_valid;
    logic [DATA_W-1:0]   r_dump_data;
    logic                r_done;
    logic                r_timed_out;
    logic [c_RUN_W-1:0]  r_run_cnt;

    logic                w_cnt_load;
    logic [c_CNT_W-1:0]  w_cnt_val;
    logic                w_cnt_dec;
    logic                w_cnt_zero;
    logic                w_cnt_one;
    logic                w_halt;
    logic                w_timeout;
    logic                w_hold_done;
    logic                w_xfer;

    assign w_halt    = is_halt(64'(instr), INSTR_W, OPCODE_W, 64'(HALT_OPCODE));
    assign w_timeout = (RUN_TIMEOUT != 0) && (r_run_cnt == c_RUN_W'(RUN_TIMEOUT - 1));
    assign w_xfer    = r_dump_valid && dump_ready;

    // The shared counter sits at zero on HOLD entry; the first HOLD cycle
    // loads HOLD_CYCLES-1 and the exit happens when it reaches one.
    assign w_hold_done = w_cnt_zero ? (HOLD_CYCLES == 1) : w_cnt_one;

    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;
        case (r_state)
            HOLD: begin
                if (!w_hold_done) begin
                    if (w_cnt_zero) begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = c_CNT_W'(HOLD_CYCLES - 1);
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_halt || w_timeout) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_CNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (w_cnt_zero) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_CNT_W'(DUMP_COUNT);
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            WAIT: begin
                w_cnt_dec = w_xfer && !w_cnt_one;
            end
            DONE: begin
                w_cnt_load = restart;
            end
            default: begin
            end
        endcase
    end

    cpu_run_cnt #(
        .WIDTH (c_CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero),
        .o_one      (w_cnt_one)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= HOLD;
            r_core_reset <= 1'b1;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_dump_valid <= 1'b0;
            r_dump_data  <= '0;
            r_done       <= 1'b0;
            r_timed_out  <= 1'b0;
            r_run_cnt    <= '0;
        end else begin
            r_mem_rd_en <= 1'b0;
            case (r_state)
                HOLD: begin
                    if (w_hold_done) begin
                        r_state      <= RUN;
                        r_core_reset <= 1'b0;
                    end
                end
                RUN: begin
                    r_run_cnt <= r_run_cnt + 1'b1;
                    if (w_halt) begin
                        r_state <= DRAIN;
                    end else if (w_timeout) begin
                        r_state     <= DRAIN;
                        r_timed_out <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_cnt_zero) begin
                        r_state     <= RD;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= ADDR_W'(DUMP_BASE);
                    end
                end
                RD: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!r_dump_valid) begin
                        r_dump_data  <= mem_rdata;
                        r_dump_valid <= 1'b1;
                    end else if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (w_cnt_one) begin
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_core_reset <= 1'b1;
                        end else begin
                            // Next read issues on the handshake edge: 3-cycle word period.
                            r_state     <= RD;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= r_mem_addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (restart) begin
                        r_state     <= HOLD;
                        r_done      <= 1'b0;
                        r_timed_out <= 1'b0;
                        r_run_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= HOLD;
                end
            endcase
        end
    end

    assign core_reset = r_core_reset;
    assign mem_rd_en  = r_mem_rd_en;
    assign mem_addr   = r_mem_addr;
    assign dump_valid = r_dump_valid;
    assign dump_data  = r_dump_data;
    assign dump_last  = r_dump_valid && w_cnt_one;
    assign done       = r_done;
    assign timed_out  = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cpu_run_ctrl : directed self-checking bench for cpu_run_ctrl
// Rev 1.0
// ============================================================================
module tb_cpu_run_ctrl;
    import cpu_run_pkg::*;

    logic        clk = 1'b0;
    int          vec_n = 0;
    int          miss_n = 0;

    // Instance A: default parameters
    logic        rst_a, restart_a, core_reset_a, rd_a, valid_a, ready_a;
    logic        last_a, done_a, to_a;
    logic [15:0] instr_a, rdata_a, data_a;
    logic [7:0]  addr_a;

    // Instance B: wrapping 4-word window, short timeout
    logic        rst_b, restart_b, core_reset_b, rd_b, valid_b, ready_b;
    logic        last_b, done_b, to_b;
    logic [15:0] instr_b, rdata_b, data_b;
    logic [7:0]  addr_b;

    always #5 clk = ~clk;

    cpu_run_ctrl u_dut_a (
        .clk(clk), .reset(rst_a), .restart(restart_a), .instr(instr_a),
        .core_reset(core_reset_a), .mem_rd_en(rd_a), .mem_addr(addr_a),
        .mem_rdata(rdata_a), .dump_valid(valid_a), .dump_ready(ready_a),
        .dump_data(data_a), .dump_last(last_a), .done(done_a), .timed_out(to_a)
    );

    cpu_run_ctrl #(.DUMP_BASE(254), .DUMP_COUNT(4), .RUN_TIMEOUT(50)) u_dut_b (
        .clk(clk), .reset(rst_b), .restart(restart_b), .instr(instr_b),
        .core_reset(core_reset_b), .mem_rd_en(rd_b), .mem_addr(addr_b),
        .mem_rdata(rdata_b), .dump_valid(valid_b), .dump_ready(ready_b),
        .dump_data(data_b), .dump_last(last_b), .done(done_b), .timed_out(to_b)
    );

    function automatic logic [15:0] mem_val(input logic [7:0] a);
        return {~a, a};
    endfunction

    always_ff @(posedge clk) begin
        if (rd_a) rdata_a <= mem_val(addr_a);
        if (rd_b) rdata_b <= mem_val(addr_b);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1; restart_a = 1'b0; restart_b = 1'b0;
        instr_a = 16'h0000; instr_b = 16'h0000; ready_a = 1'b1; ready_b = 1'b1;
        repeat (3) tick();
        vec_n++;
        if ({core_reset_a, rd_a, valid_a, last_a, done_a, to_a} !== 6'b100000 ||
            addr_a !== 8'h00 || data_a !== 16'h0000) begin
            miss_n++;
            $display("FAIL reset_a: got cr/rd/v/l/d/to=%b addr=%h data=%h expected 100000 00 0000",
                     {core_reset_a, rd_a, valid_a, last_a, done_a, to_a}, addr_a, data_a);
        end
        vec_n++;
        if ({core_reset_b, rd_b, valid_b, last_b, done_b, to_b} !== 6'b100000 ||
            addr_b !== 8'h00 || data_b !== 16'h0000) begin
            miss_n++;
            $display("FAIL reset_b: got cr/rd/v/l/d/to=%b addr=%h data=%h expected 100000 00 0000",
                     {core_reset_b, rd_b, valid_b, last_b, done_b, to_b}, addr_b, data_b);
        end
        rst_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vec_n++;
            if (core_reset_a !== (k < 4)) begin
                miss_n++;
                $display("FAIL hold_edge%0d: core_reset=%b expected %b", k, core_reset_a, (k < 4));
            end
        end
    endtask

    task automatic test_halt_decode;
        vec_n++;
        if ({is_halt(64'hE000, 16, 5, 64'h1C), is_halt(64'hE7FF, 16, 5, 64'h1C),
             is_halt(64'hE001, 16, 5, 64'h1C), is_halt(64'hE3FF, 16, 5, 64'h1C)} !== 4'b1100) begin
            miss_n++;
            $display("FAIL is_halt: got %b expected 1100",
                     {is_halt(64'hE000, 16, 5, 64'h1C), is_halt(64'hE7FF, 16, 5, 64'h1C),
                      is_halt(64'hE001, 16, 5, 64'h1C), is_halt(64'hE3FF, 16, 5, 64'h1C)});
        end
    endtask

    // Entered right after the edge where RUN starts (RUN cycle 1).
    task automatic test_halt_basic;
        int n;
        for (int i = 1; i <= 19; i++) begin
            instr_a = (i % 3 == 0) ? 16'hE001 : ((i % 3 == 1) ? 16'hE3FF : 16'h1234);
            tick();
            vec_n++;
            if (core_reset_a !== 1'b0 || rd_a !== 1'b0) begin
                miss_n++;
                $display("FAIL run_cycle%0d: core_reset=%b rd=%b expected 0 0", i, core_reset_a, rd_a);
            end
        end
        instr_a = 16'hE000;
        tick();
        instr_a = 16'h0000;
        n = 0;
        while (!rd_a && n < 40) begin tick(); n++; end
        vec_n++;
        if (n != 11 || addr_a !== 8'd1) begin
            miss_n++;
            $display("FAIL halt_to_rd: cycles=%0d addr=%0d expected 11 1", n, addr_a);
        end
        tick();
        vec_n++;
        if (rd_a !== 1'b0 || valid_a !== 1'b0) begin
            miss_n++;
            $display("FAIL rd_pulse: rd=%b valid=%b expected 0 0", rd_a, valid_a);
        end
        tick();
        vec_n++;
        if (valid_a !== 1'b1 || data_a !== 16'hFE01 || last_a !== 1'b1 || done_a !== 1'b0) begin
            miss_n++;
            $display("FAIL dump_word: v=%b data=%h last=%b done=%b expected 1 fe01 1 0",
                     valid_a, data_a, last_a, done_a);
        end
        tick();
        vec_n++;
        if ({done_a, core_reset_a, valid_a, last_a, to_a} !== 5'b11000) begin
            miss_n++;
            $display("FAIL done_state: d/cr/v/l/to=%b expected 11000",
                     {done_a, core_reset_a, valid_a, last_a, to_a});
        end
    endtask

    task automatic test_halt_alt;
        int n;
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        vec_n++;
        if (done_a !== 1'b0 || core_reset_a !== 1'b1) begin
            miss_n++;
            $display("FAIL restart_a: done=%b core_reset=%b expected 0 1", done_a, core_reset_a);
        end
        n = 0;
        while (core_reset_a && n < 20) begin tick(); n++; end
        vec_n++;
        if (n != 4) begin
            miss_n++;
            $display("FAIL rehold_a: cycles=%0d expected 4", n);
        end
        restart_a = 1'b1;
        instr_a = 16'hE3FF;
        tick();
        restart_a = 1'b0;
        vec_n++;
        if (core_reset_a !== 1'b0 || done_a !== 1'b0) begin
            miss_n++;
            $display("FAIL restart_in_run: core_reset=%b done=%b expected 0 0", core_reset_a, done_a);
        end
        instr_a = 16'hE7FF;
        tick();
        instr_a = 16'h0000;
        n = 0;
        while (!rd_a && n < 40) begin tick(); n++; end
        vec_n++;
        if (n != 11) begin
            miss_n++;
            $display("FAIL halt_e7ff: cycles=%0d expected 11", n);
        end
        n = 0;
        while (!valid_a && n < 10) begin tick(); n++; end
        vec_n++;
        if (valid_a !== 1'b1 || data_a !== 16'hFE01) begin
            miss_n++;
            $display("FAIL e7ff_data: v=%b data=%h expected 1 fe01", valid_a, data_a);
        end
        tick();
        vec_n++;
        if (done_a !== 1'b1) begin
            miss_n++;
            $display("FAIL e7ff_done: done=%b expected 1", done_a);
        end
    endtask

    task automatic test_reset_mid_dump;
        int n;
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        n = 0;
        while (core_reset_a && n < 20) begin tick(); n++; end
        instr_a = 16'hE000;
        tick();
        instr_a = 16'h0000;
        ready_a = 1'b0;
        n = 0;
        while (!valid_a && n < 40) begin tick(); n++; end
        vec_n++;
        if (valid_a !== 1'b1) begin
            miss_n++;
            $display("FAIL pre_reset_valid: valid=%b expected 1", valid_a);
        end
        #2 rst_a = 1'b1;
        #1;
        vec_n++;
        if ({core_reset_a, rd_a, valid_a, last_a, done_a, to_a} !== 6'b100000 ||
            addr_a !== 8'h00 || data_a !== 16'h0000) begin
            miss_n++;
            $display("FAIL async_reset: cr/rd/v/l/d/to=%b addr=%h data=%h expected 100000 00 0000",
                     {core_reset_a, rd_a, valid_a, last_a, done_a, to_a}, addr_a, data_a);
        end
        #1 rst_a = 1'b0;
        ready_a = 1'b1;
        tick();
        n = 1;
        while (core_reset_a && n < 20) begin tick(); n++; end
        vec_n++;
        if (n != 4) begin
            miss_n++;
            $display("FAIL rerun_hold: cycles=%0d expected 4", n);
        end
        instr_a = 16'hE000;
        tick();
        instr_a = 16'h0000;
        n = 0;
        while (!done_a && n < 40) begin
            tick(); n++;
            if (valid_a) begin
                vec_n++;
                if (data_a !== 16'hFE01 || last_a !== 1'b1) begin
                    miss_n++;
                    $display("FAIL rerun_data: data=%h last=%b expected fe01 1", data_a, last_a);
                end
            end
        end
        vec_n++;
        if (done_a !== 1'b1 || n != 14) begin
            miss_n++;
            $display("FAIL rerun_done: done=%b cycles=%0d expected 1 14", done_a, n);
        end
    endtask

    task automatic test_wrap_backpressure;
        int n, rd_idx, wd, stall, cyc;
        int rd_cyc [4];
        logic [7:0]  exp_addr [4];
        logic [15:0] exp_data [4];
        logic [15:0] held;
        exp_addr[0] = 8'd254; exp_addr[1] = 8'd255; exp_addr[2] = 8'd0; exp_addr[3] = 8'd1;
        exp_data[0] = 16'h01FE; exp_data[1] = 16'h00FF; exp_data[2] = 16'hFF00; exp_data[3] = 16'hFE01;
        rst_b = 1'b0;
        n = 0;
        while (core_reset_b && n < 20) begin tick(); n++; end
        vec_n++;
        if (n != 4) begin
            miss_n++;
            $display("FAIL hold_b: cycles=%0d expected 4", n);
        end
        instr_b = 16'hE000;
        tick();
        instr_b = 16'h0000;
        rd_idx = 0; wd = 0; stall = 0; held = 16'h0; cyc = 0;
        ready_b = 1'b1;
        while (!done_b && cyc < 200) begin
            tick(); cyc++;
            if (rd_b) begin
                vec_n++;
                if (rd_idx > 3 || stall > 0) begin
                    miss_n++;
                    $display("FAIL extra_rd: index=%0d stall=%0d expected no read", rd_idx, stall);
                end else begin
                    if (addr_b !== exp_addr[rd_idx]) begin
                        miss_n++;
                        $display("FAIL wrap_addr%0d: addr=%0d expected %0d", rd_idx, addr_b, exp_addr[rd_idx]);
                    end
                    rd_cyc[rd_idx] = cyc;
                end
                rd_idx++;
            end
            if (valid_b) begin
                vec_n++;
                if (stall > 0) begin
                    if (data_b !== held || last_b !== 1'b0) begin
                        miss_n++;
                        $display("FAIL stall_hold: data=%h last=%b expected %h 0", data_b, last_b, held);
                    end
                    stall--;
                    if (stall == 0) begin ready_b = 1'b1; wd++; end
                end else if (wd > 3) begin
                    miss_n++;
                    $display("FAIL extra_word: index=%0d expected none", wd);
                end else begin
                    if (data_b !== exp_data[wd] || last_b !== (wd == 3)) begin
                        miss_n++;
                        $display("FAIL word%0d: data=%h last=%b expected %h %b",
                                 wd, data_b, last_b, exp_data[wd], (wd == 3));
                    end
                    if (wd == 1) begin ready_b = 1'b0; stall = 5; held = data_b; end
                    else wd++;
                end
            end
        end
        vec_n++;
        if (done_b !== 1'b1 || rd_idx != 4 || wd != 4 || to_b !== 1'b0) begin
            miss_n++;
            $display("FAIL wrap_end: done=%b reads=%0d words=%0d to=%b expected 1 4 4 0",
                     done_b, rd_idx, wd, to_b);
        end
        vec_n++;
        if (rd_idx >= 2 && rd_cyc[1] - rd_cyc[0] != 3) begin
            miss_n++;
            $display("FAIL throughput: period=%0d expected 3", rd_cyc[1] - rd_cyc[0]);
        end
    endtask

    task automatic test_timeout;
        int n;
        restart_b = 1'b1;
        tick();
        restart_b = 1'b0;
        n = 0;
        while (core_reset_b && n < 20) begin tick(); n++; end
        instr_b = 16'h0000;
        for (int t = 1; t <= 61; t++) begin
            tick();
            if (t == 49 || t == 50) begin
                vec_n++;
                if (to_b !== (t == 50)) begin
                    miss_n++;
                    $display("FAIL timed_out_t%0d: to=%b expected %b", t, to_b, (t == 50));
                end
            end
            if (t == 60 || t == 61) begin
                vec_n++;
                if (rd_b !== (t == 61) || (t == 61 && addr_b !== 8'd254)) begin
                    miss_n++;
                    $display("FAIL timeout_rd_t%0d: rd=%b addr=%0d expected %b 254", t, rd_b, addr_b, (t == 61));
                end
            end
        end
        n = 0;
        while (!done_b && n < 40) begin tick(); n++; end
        vec_n++;
        if (done_b !== 1'b1 || to_b !== 1'b1) begin
            miss_n++;
            $display("FAIL timeout_done: done=%b to=%b expected 1 1", done_b, to_b);
        end
        restart_b = 1'b1;
        tick();
        restart_b = 1'b0;
        vec_n++;
        if (to_b !== 1'b0 || core_reset_b !== 1'b1 || done_b !== 1'b0) begin
            miss_n++;
            $display("FAIL timeout_restart: to=%b cr=%b done=%b expected 0 1 0", to_b, core_reset_b, done_b);
        end
        n = 0;
        while (core_reset_b && n < 20) begin tick(); n++; end
        vec_n++;
        if (n != 4) begin
            miss_n++;
            $display("FAIL timeout_rehold: cycles=%0d expected 4", n);
        end
    endtask

    // Halt on the same cycle the timeout would fire: counts as a halt.
    task automatic test_halt_at_timeout;
        int n;
        instr_b = 16'h0000;
        repeat (49) tick();
        instr_b = 16'hE7FF;
        tick();
        instr_b = 16'h0000;
        vec_n++;
        if (to_b !== 1'b0) begin
            miss_n++;
            $display("FAIL tie_timed_out: to=%b expected 0", to_b);
        end
        n = 0;
        while (!rd_b && n < 40) begin tick(); n++; end
        vec_n++;
        if (n != 11) begin
            miss_n++;
            $display("FAIL tie_rd: cycles=%0d expected 11", n);
        end
        n = 0;
        while (!done_b && n < 40) begin tick(); n++; end
        vec_n++;
        if (done_b !== 1'b1 || to_b !== 1'b0) begin
            miss_n++;
            $display("FAIL tie_done: done=%b to=%b expected 1 0", done_b, to_b);
        end
    endtask

    initial begin
        test_reset();
        test_halt_decode();
        test_halt_basic();
        test_halt_alt();
        test_reset_mid_dump();
        test_wrap_backpressure();
        test_timeout();
        test_halt_at_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
